// File: rtl/mdom_wvb_hdr_pkg.sv
// Shared definitions for the waveform-buffer header serializer:
// default widths, serializer state encoding and word-count helper.
package mdom_wvb_hdr_pkg;

  localparam int unsigned HDR_W_DEF   = 106;
  localparam int unsigned SHORT_W_DEF = 64;
  localparam int unsigned WORD_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } ser_state_t;

  // Number of words needed to carry bits_w bits in words of word_w bits.
  function automatic int unsigned word_count(input int unsigned bits_w,
                                             input int unsigned word_w);
    return (bits_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/mdom_hdr_fifo.sv
// Synchronous header FIFO. Writes into a full FIFO and reads from an empty
// FIFO are ignored. Read data is presented combinationally from the head.
module mdom_hdr_fifo #(
  parameter int unsigned P_WIDTH = 107,
  parameter int unsigned P_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [P_WIDTH-1:0]         wr_data,
  input  logic                       rd_en,
  output logic [P_WIDTH-1:0]         rd_data,
  output logic [$clog2(P_DEPTH):0]   count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_wr;
  logic               do_rd;

  assign full    = (count == CW'(P_DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy; a simultaneous write and read leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mdom_wvb_hdr_serializer.sv
// Buffers packed waveform headers and streams each one out as a frame of
// LSB-first words with start/end-of-frame markers. Short headers send only
// the low P_SHORT_W bits. The entry stays counted until its last word is
// accepted.
module mdom_wvb_hdr_serializer
  import mdom_wvb_hdr_pkg::*;
#(
  parameter int unsigned P_HDR_W   = HDR_W_DEF,
  parameter int unsigned P_SHORT_W = SHORT_W_DEF,
  parameter int unsigned P_WORD_W  = WORD_W_DEF,
  parameter int unsigned P_DEPTH   = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [P_HDR_W-1:0]        hdr_bundle,
  input  logic                      hdr_wr,
  input  logic                      hdr_short,
  output logic [P_WORD_W-1:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sof,
  output logic                      out_eof,
  output logic [$clog2(P_DEPTH):0]  fifo_cnt,
  output logic                      full,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam int unsigned NL    = word_count(P_HDR_W, P_WORD_W);
  localparam int unsigned NS    = word_count(P_SHORT_W, P_WORD_W);
  localparam int unsigned SH_W  = NL * P_WORD_W;
  localparam int unsigned IDX_W = $clog2(NL + 1);
  localparam int unsigned FW    = P_HDR_W + 1;

  ser_state_t         state;
  ser_state_t         state_nxt;
  logic [FW-1:0]      rd_data;
  logic               fifo_empty;
  logic [SH_W-1:0]    shreg;
  logic [SH_W-1:0]    load_val;
  logic [SH_W-1:0]    short_mask;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   nwords;
  logic               load_en;
  logic               fire;
  logic               last_word;
  logic               pop;

  // The short flag is stored alongside the header as the top bit.
  mdom_hdr_fifo #(
    .P_WIDTH (FW),
    .P_DEPTH (P_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (hdr_wr),
    .wr_data ({hdr_short, hdr_bundle}),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (fifo_cnt),
    .full    (full),
    .empty   (fifo_empty)
  );

  assign last_word = (idx == nwords - IDX_W'(1));
  assign fire      = out_valid && out_ready;
  assign pop       = fire && last_word;

  // Serializer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: one LOAD cycle between frames, leave SEND on last acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!fifo_empty) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: if (pop) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and frame markers derived from state and word index.
  always_comb begin
    out_valid = (state == ST_SEND);
    load_en   = (state == ST_LOAD);
    out_sof   = out_valid && (idx == '0);
    out_eof   = out_valid && last_word;
    out_data  = out_valid ? shreg[P_WORD_W-1:0] : '0;
  end

  // Zero-extend the head entry; short headers are masked to their width so
  // the final short word is padded with zeros.
  always_comb begin
    short_mask                = '0;
    short_mask[P_SHORT_W-1:0] = '1;
    load_val                  = SH_W'(rd_data[P_HDR_W-1:0]);
    if (rd_data[P_HDR_W]) begin
      load_val = load_val & short_mask;
    end
  end

  // Shift register advances one word per acceptance and holds on stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      idx    <= '0;
      nwords <= '0;
    end else if (load_en) begin
      shreg  <= load_val;
      idx    <= '0;
      nwords <= rd_data[P_HDR_W] ? IDX_W'(NS) : IDX_W'(NL);
    end else if (fire) begin
      shreg  <= shreg >> P_WORD_W;
      idx    <= idx + IDX_W'(1);
    end
  end

  // Sticky overflow: a dropped write wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (hdr_wr && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: doc/mdom_wvb_hdr_serializer.md
MDOM_WVB_HDR_SERIALIZER -- requirements
Module: mdom_wvb_hdr_serializer

Interface
REQ-001 The parameter P_HDR_W SHALL default to 106 and set the full-header bundle width.
REQ-002 The parameter P_SHORT_W SHALL default to 64 and set the short-header width, taken from the low bits of the bundle; it SHALL be at most P_HDR_W.
REQ-003 The parameter P_WORD_W SHALL default to 16 and set the output word width.
REQ-004 The parameter P_DEPTH SHALL default to 8, SHALL be a power of two, and set the number of header entries buffered.
REQ-005 The port clk SHALL be an input, 1 bit wide, and is the single clock for all logic.
REQ-006 The port rst_n SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-007 The port hdr_bundle SHALL be an input, P_HDR_W bits wide, and carries the packed header (evt_ltc in the LSBs).
REQ-008 The port hdr_wr SHALL be an input, 1 bit wide, and is a one-cycle write strobe that captures hdr_bundle and hdr_short.
REQ-009 The port hdr_short SHALL be an input, 1 bit wide; when 1, only the P_SHORT_W LSBs are serialized.
REQ-010 The port out_data SHALL be an output, P_WORD_W bits wide, and carries the serialized word.
REQ-011 The ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_sof (output, 1 bit) and out_eof (output, 1 bit) SHALL implement the word handshake and the frame markers.
REQ-012 The port fifo_cnt SHALL be an output, clog2(P_DEPTH)+1 bits wide, and gives the number of entries stored, including the entry being sent.
REQ-013 The ports full (output, 1 bit), ovf (output, 1 bit, sticky) and ovf_clr (input, 1 bit) SHALL report and clear the overflow condition.

Function
REQ-014 A header SHALL be stored when hdr_wr=1 and the registered full=0, together with its hdr_short bit.
REQ-015 When hdr_wr=1 and full=1, the header SHALL be dropped and ovf SHALL be set; a pop in the same cycle SHALL NOT rescue the write.
REQ-016 When ovf_clr=1, ovf SHALL be cleared; if a drop occurs in the same cycle, setting SHALL win.
REQ-017 The serializer SHALL be a state machine with the states IDLE, LOAD and SEND: IDLE goes to LOAD when fifo_cnt≠0, LOAD goes to SEND after one cycle (this cycle loads the shift register), and SEND goes to IDLE after the last word is accepted.
REQ-018 The latency SHALL be: hdr_wr in cycle 0 into an empty, idle block gives out_valid=1 in cycle 3.
REQ-019 The word count SHALL be NL=ceil(P_HDR_W/P_WORD_W) for a full header and NS=ceil(P_SHORT_W/P_WORD_W) for a short header (7 and 4 at the defaults).
REQ-020 Words SHALL be emitted LSB first: word k = bits [k*P_WORD_W +: P_WORD_W], with the final word zero-padded above the header width.
REQ-021 A word SHALL transfer on out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0, out_data, out_sof and out_eof SHALL hold stable.
REQ-022 out_sof SHALL be 1 only on word 0, and out_eof SHALL be 1 only on the last word.
REQ-023 out_valid SHALL NOT deassert mid-frame.
REQ-024 The entry SHALL be popped (fifo_cnt decremented) on acceptance of its last word.
REQ-025 A simultaneous write and pop SHALL leave fifo_cnt unchanged.
REQ-026 Back-to-back frames SHALL incur the two-cycle IDLE/LOAD gap.
REQ-027 The read and write pointers SHALL wrap modulo P_DEPTH.
REQ-028 full SHALL equal (fifo_cnt==P_DEPTH).

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously clear the pointers, fifo_cnt, ovf and the shift register, force out_valid, out_sof, out_eof and full to 0, drive out_data to 0, and enter IDLE.
REQ-030 A reset asserted mid-frame SHALL abort the frame; no partial frame SHALL resume after reset.
REQ-031 Storage RAM contents SHALL NOT be required to reset.

Structure
REQ-032 Package mdom_wvb_hdr_pkg SHALL hold the default widths, the FSM state enum, and the ceil-division word-count function.
REQ-033 The buffer SHALL be the sub-module mdom_hdr_fifo: a synchronous FIFO with parameters width P_HDR_W+1 and P_DEPTH, providing count, full and empty.

Verification
REQ-034 Scenario: single full header 0x2AB_CDEF_0123_4567_89AB_CDEF with hdr_short=0 and out_ready=1 -> 7 words 0xCDEF, 0x89AB, 0x4567, 0x0123, 0xCDEF, 0x2AB, 0x0000; sof on word 1, eof on word 7, first valid in cycle 3.
REQ-035 Scenario: the same header with hdr_short=1 -> 4 words ending 0x0123 with eof; fifo_cnt returns to 0.
REQ-036 Scenario: 9 writes with out_ready=0 -> fifo_cnt=8, full=1, ninth write dropped, ovf=1; after ovf_clr, ovf=0.
REQ-037 Scenario: out_ready toggling 1/0 every cycle -> out_data is held during stalls and all 8 frames are intact and in order.
REQ-038 Scenario: write coinciding with acceptance of the last word at fifo_cnt=3 -> fifo_cnt stays 3; at fifo_cnt=8, the write is dropped and ovf=1.
REQ-039 Scenario: rst_n pulsed low at word 3 of a frame -> outputs are 0 immediately, fifo_cnt=0, and the next write yields a clean frame.
